// File: rtl/bus_clock_recovery.sv
// bus_clock_recovery: rebuilds the Amiga bus-clock phases (CCK, CCKQ, CDAC edges)
// in the 56 MHz PLL domain from a single asynchronous CCK pin.
//
// Ports:
//   clk         56 MHz PLL clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   cck_in      asynchronous CCK pin
//   err_clr     clears the sticky period_err flag
//   cck, cckq   recovered clock phases (delay-line taps 0 and CCKQ_TAP)
//   cck_edge    1-clk strobe on any cck transition
//   cck_rise    1-clk strobe on cck 0->1
//   cck_fall    1-clk strobe on cck 1->0
//   cckq_edge   1-clk strobe on any cckq transition
//   cdac_edge   1-clk strobe on a transition at CDAC_TAP_A or CDAC_TAP_B
//   phase       clk slots since the last cck rise (0 alongside cck_rise)
//   locked      CCK period lock status
//   period_err  sticky flag, set when lock is lost from the locked state
module bus_clock_recovery #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TAP_DEPTH   = 8,
  parameter int unsigned CCKQ_TAP    = 4,
  parameter int unsigned CDAC_TAP_A  = 2,
  parameter int unsigned CDAC_TAP_B  = 6,
  parameter int unsigned PERIOD_NOM  = 16,
  parameter int unsigned PERIOD_TOL  = 1,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned GATE_UNLOCK = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cck_in,
  input  logic             err_clr,
  output logic             cck,
  output logic             cckq,
  output logic             cck_edge,
  output logic             cck_rise,
  output logic             cck_fall,
  output logic             cckq_edge,
  output logic             cdac_edge,
  output logic [CNT_W-1:0] phase,
  output logic             locked,
  output logic             period_err
);

  // Sync chain and delay line form one shift register; d[0] is the last sync flop,
  // so cck lags cck_in by exactly SYNC_STAGES clocks.
  localparam int unsigned LINE_W = SYNC_STAGES + TAP_DEPTH - 1;
  localparam int unsigned D0     = SYNC_STAGES - 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned P_MIN  = PERIOD_NOM - PERIOD_TOL;
  localparam int unsigned P_MAX  = PERIOD_NOM + PERIOD_TOL;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2
  } state_e;

  logic [LINE_W-1:0]    line_q, line_d;
  logic [TAP_DEPTH-1:0] d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  state_e               state_q, state_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 cck_edge_q, cck_edge_d;
  logic                 cck_rise_q, cck_rise_d;
  logic                 cck_fall_q, cck_fall_d;
  logic                 cckq_edge_q, cckq_edge_d;
  logic                 cdac_edge_q, cdac_edge_d;

  logic                 rise_c;
  logic                 good_c;
  logic                 timeout_c;
  logic                 gate_c;
  logic                 err_set_c;
  logic [CNT_W:0]       period_c;

  assign d = line_q[LINE_W-1:D0];

  // Next-state logic: delay line, slot counter, lock FSM, gated strobes.
  always_comb begin
    line_d      = {line_q[LINE_W-2:0], cck_in};
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    err_set_c   = 1'b0;

    rise_c    = d[0] & ~d[1];
    period_c  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    good_c    = (period_c >= (CNT_W+1)'(P_MIN)) && (period_c <= (CNT_W+1)'(P_MAX));
    timeout_c = !rise_c && (cnt_q >= CNT_W'(P_MAX));

    // Counter restarts on every rise and saturates so a dead clock never wraps.
    if (rise_c) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      // First measured period is meaningless (counter start is arbitrary).
      S_UNLOCKED: begin
        if (rise_c) begin
          state_d    = S_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      S_ACQUIRE: begin
        if (rise_c) begin
          if (good_c) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_d = S_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout_c) begin
          state_d = S_UNLOCKED;
        end
      end
      S_LOCKED: begin
        if ((rise_c && !good_c) || timeout_c) begin
          state_d   = S_UNLOCKED;
          err_set_c = 1'b1;
        end
      end
      default: begin
        state_d = S_UNLOCKED;
      end
    endcase

    locked_d = (state_d == S_LOCKED);
    err_d    = err_set_c | (err_q & ~err_clr);

    // Gate with the lock status of the cycle the strobe is shown in.
    gate_c = (GATE_UNLOCK != 0) ? locked_d : 1'b1;

    cck_edge_d  = (d[0] ^ d[1]) & gate_c;
    cck_rise_d  = rise_c & gate_c;
    cck_fall_d  = ~d[0] & d[1] & gate_c;
    cckq_edge_d = (d[CCKQ_TAP] ^ d[CCKQ_TAP+1]) & gate_c;
    cdac_edge_d = ((d[CDAC_TAP_A] ^ d[CDAC_TAP_A+1]) |
                   (d[CDAC_TAP_B] ^ d[CDAC_TAP_B+1])) & gate_c;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_q      <= '0;
      cnt_q       <= '0;
      good_cnt_q  <= '0;
      state_q     <= S_UNLOCKED;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      cck_edge_q  <= 1'b0;
      cck_rise_q  <= 1'b0;
      cck_fall_q  <= 1'b0;
      cckq_edge_q <= 1'b0;
      cdac_edge_q <= 1'b0;
    end else begin
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      cck_edge_q  <= cck_edge_d;
      cck_rise_q  <= cck_rise_d;
      cck_fall_q  <= cck_fall_d;
      cckq_edge_q <= cckq_edge_d;
      cdac_edge_q <= cdac_edge_d;
    end
  end

  assign cck        = d[0];
  assign cckq       = d[CCKQ_TAP];
  assign cck_edge   = cck_edge_q;
  assign cck_rise   = cck_rise_q;
  assign cck_fall   = cck_fall_q;
  assign cckq_edge  = cckq_edge_q;
  assign cdac_edge  = cdac_edge_q;
  assign phase      = cnt_q;
  assign locked     = locked_q;
  assign period_err = err_q;

endmodule

// File: tb/tb_bus_clock_recovery.sv
// Directed bench for bus_clock_recovery: default instance plus a deeper
// SYNC_STAGES=3 / TAP_DEPTH=10 / CCKQ_TAP=5 instance sharing the same pins.
module tb_bus_clock_recovery;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cck_in;
  logic       err_clr;

  logic       cck, cckq, cck_edge, cck_rise, cck_fall, cckq_edge, cdac_edge;
  logic [4:0] phase;
  logic       locked, period_err;

  logic       cck6, cckq6, cck_edge6, cck_rise6, cck_fall6, cckq_edge6, cdac_edge6;
  logic [4:0] phase6;
  logic       locked6, period_err6;

  always #5 clk = ~clk;

  bus_clock_recovery dut (
    .clk(clk), .reset_n(reset_n), .cck_in(cck_in), .err_clr(err_clr),
    .cck(cck), .cckq(cckq), .cck_edge(cck_edge), .cck_rise(cck_rise),
    .cck_fall(cck_fall), .cckq_edge(cckq_edge), .cdac_edge(cdac_edge),
    .phase(phase), .locked(locked), .period_err(period_err)
  );

  bus_clock_recovery #(.SYNC_STAGES(3), .TAP_DEPTH(10), .CCKQ_TAP(5)) dut6 (
    .clk(clk), .reset_n(reset_n), .cck_in(cck_in), .err_clr(err_clr),
    .cck(cck6), .cckq(cckq6), .cck_edge(cck_edge6), .cck_rise(cck_rise6),
    .cck_fall(cck_fall6), .cckq_edge(cckq_edge6), .cdac_edge(cdac_edge6),
    .phase(phase6), .locked(locked6), .period_err(period_err6)
  );

  int   t = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rise, n_fall, n_e, n_q, n_cdac;
  int   last_rise_t = 0;
  int   lock_t = 0, unlock_t = 0, err_t = 0;
  int   cck_up_t = 0, cckq_up_t = 0, cck6_up_t = 0, cckq6_up_t = 0;
  int   rise_s = 0;
  int   sb, sr, g;
  logic prev_locked = 1'b0, prev_err = 1'b0;
  logic prev_cck = 1'b0, prev_cckq = 1'b0, prev_cck6 = 1'b0, prev_cckq6 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
  endtask

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_e = 0; n_q = 0; n_cdac = 0;
  endtask

  // Advance one clock, sample 1 time unit after the edge and log events.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (cck_rise)  begin n_rise++; last_rise_t = t; end
    if (cck_fall)  n_fall++;
    if (cck_edge)  n_e++;
    if (cckq_edge) n_q++;
    if (cdac_edge) n_cdac++;
    if (locked && !prev_locked) lock_t = t;
    if (!locked && prev_locked) unlock_t = t;
    if (period_err && !prev_err) err_t = t;
    if (cck && !prev_cck)     cck_up_t = t;
    if (cckq && !prev_cckq)   cckq_up_t = t;
    if (cck6 && !prev_cck6)   cck6_up_t = t;
    if (cckq6 && !prev_cckq6) cckq6_up_t = t;
    prev_locked = locked; prev_err = period_err;
    prev_cck = cck; prev_cckq = cckq; prev_cck6 = cck6; prev_cckq6 = cckq6;
  endtask

  task automatic step(input logic v);
    cck_in = v;
    tick();
  endtask

  // One cck_in period; rise_s is the clock index that first samples the high level.
  task automatic period(input int hi, input int lo);
    rise_s = t + 1;
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  initial begin
    clear_counts();
    reset_n = 1'b0; cck_in = 1'b0; err_clr = 1'b0;

    // T1: reset state, lock after the 5th rise, nominal strobe pattern
    repeat (3) tick();
    check("rst_outs", 32'({cck, cckq, cck_edge, cck_rise, cck_fall, cckq_edge,
                           cdac_edge, locked, period_err, phase}), 32'd0);
    check("rst_outs6", 32'({cck6, cckq6, cck_edge6, cck_rise6, cck_fall6, cckq_edge6,
                            cdac_edge6, locked6, period_err6, phase6}), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) period(8, 8);
    check("t1_lock_time", 32'(lock_t), 32'(rise_s + 2));
    check("t1_locked", 32'(locked), 32'd1);
    check("t6_locked", 32'(locked6), 32'd1);

    clear_counts();
    period(8, 8);
    check("t1_rise_cnt", 32'(n_rise), 32'd1);
    check("t1_rise_time", 32'(last_rise_t), 32'(rise_s + 2));
    check("t1_fall_cnt", 32'(n_fall), 32'd1);
    check("t1_cck_edges", 32'(n_e), 32'd2);
    check("t1_cckq_edges", 32'(n_q), 32'd2);
    check("t1_cdac_edges", 32'(n_cdac), 32'd4);
    check("t1_cck_lag", 32'(cck_up_t), 32'(rise_s + 1));
    check("t1_cckq_vs_cck", 32'(cckq_up_t - cck_up_t), 32'd4);
    check("t1_phase", 32'(phase), 32'd13);
    check("t6_cck_lag", 32'(cck6_up_t), 32'(rise_s + 2));
    check("t6_cckq_lag", 32'(cckq6_up_t), 32'(rise_s + 7));

    // T2: 17 and 15 tolerated, 18 unlocks; gated strobes until relock
    period(9, 8);
    period(8, 7);
    period(9, 9);
    check("t2_jitter_locked", 32'(locked), 32'd1);
    clear_counts();
    period(8, 8);
    sb = rise_s;
    check("t2_unlock_time", 32'(unlock_t), 32'(sb + 2));
    check("t2_err_time", 32'(err_t), 32'(sb + 2));
    check("t2_err", 32'(period_err), 32'd1);
    for (int i = 0; i < 4; i++) period(8, 8);
    check("t2_gated_rise", 32'(n_rise), 32'd0);
    check("t2_gated_cdac", 32'(n_cdac), 32'd0);
    check("t2_gated_edge", 32'(n_e), 32'd0);
    check("t2_still_unlocked", 32'(locked), 32'd0);
    period(8, 8);
    check("t2_relock_time", 32'(lock_t), 32'(sb + 82));
    check("t2_relock_rise", 32'(n_rise), 32'd1);

    // T3: hold cck_in low -> timeout at cnt 17, counter saturates
    sr = rise_s;
    err_clr = 1'b1; step(1'b0); err_clr = 1'b0;
    check("t3_err_clr", 32'(period_err), 32'd0);
    while (t < sr + 55) begin
      step(1'b0);
      if (t == sr + 19) begin
        check("t3_phase17", 32'(phase), 32'd17);
        check("t3_locked_at17", 32'(locked), 32'd1);
      end
    end
    check("t3_unlock_time", 32'(unlock_t), 32'(sr + 20));
    check("t3_err_time", 32'(err_t), 32'(sr + 20));
    check("t3_phase_sat", 32'(phase), 32'd31);

    // T4: short glitch unlocks; set beats err_clr in the same cycle
    err_clr = 1'b1; step(1'b0); err_clr = 1'b0;
    check("t4_err_clr0", 32'(period_err), 32'd0);
    for (int i = 0; i < 5; i++) period(8, 8);
    check("t4_locked", 32'(locked), 32'd1);
    repeat (8) step(1'b1);
    repeat (3) step(1'b0);
    g = t + 1;
    step(1'b1);
    step(1'b1);
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    check("t4_glitch_unlock", 32'(unlock_t), 32'(g + 2));
    check("t4_set_beats_clr", 32'(period_err), 32'd1);
    repeat (5) step(1'b0);
    err_clr = 1'b1; step(1'b0); err_clr = 1'b0;
    check("t4_err_clr_late", 32'(period_err), 32'd0);

    // T5: one-clock reset while locked, then relock after five rises
    for (int i = 0; i < 5; i++) period(8, 8);
    check("t5_locked", 32'(locked), 32'd1);
    repeat (8) step(1'b1);
    repeat (2) step(1'b0);
    check("t5_pre_cckq", 32'(cckq), 32'd1);
    reset_n = 1'b0;
    step(1'b0);
    check("t5_rst_outs", 32'({cck, cckq, cck_edge, cck_rise, cck_fall, cckq_edge,
                              cdac_edge, locked, period_err, phase}), 32'd0);
    reset_n = 1'b1;
    repeat (5) step(1'b0);
    check("t5_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) period(8, 8);
    check("t5_relock_time", 32'(lock_t), 32'(rise_s + 2));
    check("t5_relocked", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
